// File: rtl/neighbor_scan.sv
// Purpose: scans a word-memory neighbor table and lists the IDs of neighbors whose cluster differs from ours.
// Latency: done pulses 3+2n+m cycles after start is accepted (n = clamped neighbor count, m = list writes).
// Backpressure: none; start is only accepted in IDLE and ignored while a scan is in flight.
//
// Ports:
//   clock, nrst         - clock and asynchronous active-low reset
//   start, my_cluster_id- one-cycle scan request and own cluster ID (sampled on acceptance)
//   mem_addr/mem_wr_en/mem_wdata/mem_rdata - word memory port (even byte addresses, combinational read)
//   busy, done          - scan in progress, one-cycle completion pulse
//   match_count, overflow - entries written to the output list, list-full drop indication
module neighbor_scan #(
    parameter logic [15:0] NBR_COUNT_ADDR = 16'h068A,
    parameter logic [15:0] NBR_ID_BASE    = 16'h0048,
    parameter logic [15:0] CLUSTER_BASE   = 16'h00C8,
    parameter logic [15:0] OUT_BASE       = 16'h0668,
    parameter logic [15:0] OUT_COUNT_ADDR = 16'h068C,
    parameter int          MAX_NBR        = 64,
    parameter int          MAX_OUT        = 16
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        start,
    input  logic [15:0] my_cluster_id,
    output logic [15:0] mem_addr,
    output logic        mem_wr_en,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [4:0]  match_count,
    output logic        overflow
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_CNT = 3'd1,
        RD_ID  = 3'd2,
        RD_CL  = 3'd3,
        WR_OUT = 3'd4,
        WR_CNT = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [6:0]  n_q, n_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [15:0] myc_q, myc_d;
    logic [15:0] id_q, id_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        myc_d   = myc_q;
        id_d    = id_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    myc_d   = my_cluster_id;
                    cnt_d   = 5'd0;
                    ovf_d   = 1'b0;
                    state_d = RD_CNT;
                end
            end
            RD_CNT: begin
                if (mem_rdata > 16'(MAX_NBR)) n_d = 7'(MAX_NBR);
                else                          n_d = mem_rdata[6:0];
                idx_d   = 7'd0;
                state_d = (n_d == 7'd0) ? WR_CNT : RD_ID;
            end
            RD_ID: begin
                id_d    = mem_rdata;
                state_d = RD_CL;
            end
            RD_CL: begin
                if ((mem_rdata != myc_q) && (cnt_q < 5'(MAX_OUT))) begin
                    state_d = WR_OUT;
                end else begin
                    // A mismatch here means the list is already full: drop and flag it.
                    if (mem_rdata != myc_q) ovf_d = 1'b1;
                    idx_d   = idx_q + 7'd1;
                    state_d = (idx_d == n_q) ? WR_CNT : RD_ID;
                end
            end
            WR_OUT: begin
                // Count increments on leaving WR_OUT so the write address uses the old value.
                cnt_d   = cnt_q + 5'd1;
                idx_d   = idx_q + 7'd1;
                state_d = (idx_d == n_q) ? WR_CNT : RD_ID;
            end
            WR_CNT:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered.
        addr_d  = 16'h0000;
        wr_d    = 1'b0;
        wdata_d = 16'h0000;
        case (state_d)
            RD_CNT: addr_d = NBR_COUNT_ADDR;
            RD_ID:  addr_d = NBR_ID_BASE + {8'b0, idx_d, 1'b0};
            RD_CL:  addr_d = CLUSTER_BASE + {8'b0, idx_d, 1'b0};
            WR_OUT: begin
                addr_d  = OUT_BASE + {10'b0, cnt_d, 1'b0};
                wr_d    = 1'b1;
                wdata_d = id_d;
            end
            WR_CNT: begin
                addr_d  = OUT_COUNT_ADDR;
                wr_d    = 1'b1;
                wdata_d = {11'b0, cnt_d};
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            idx_q   <= 7'd0;
            n_q     <= 7'd0;
            cnt_q   <= 5'd0;
            ovf_q   <= 1'b0;
            myc_q   <= 16'h0000;
            id_q    <= 16'h0000;
            addr_q  <= 16'h0000;
            wr_q    <= 1'b0;
            wdata_q <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            myc_q   <= myc_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wr_en   = wr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign match_count = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_neighbor_scan.sv
// Bench for neighbor_scan: table of scan scenarios, hand-written reset/start-hold sequences,
// and randomized tables checked against a list-building reference model.
module tb_neighbor_scan;

    localparam int CNT_W = 'h345;   // word index of neighborCount (0x068A)
    localparam int ID_W  = 'h24;    // word index of neighborID[0] (0x0048)
    localparam int CL_W  = 'h64;    // word index of clusterID[0]  (0x00C8)

    logic        clock = 1'b0;
    logic        nrst;
    logic        start;
    logic [15:0] my_cluster_id;
    logic [15:0] mem_addr;
    logic        mem_wr_en;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [4:0]  match_count;
    logic        overflow;

    logic [15:0] mem [0:32767];
    logic [31:0] wr_q [$];
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int prot_err = 0;

    typedef struct {
        int          cnt;
        int          pat;
        logic [15:0] myc;
        int          exp_m;
        logic        exp_ovf;
        int          exp_cyc;
    } vec_t;

    neighbor_scan dut (
        .clock         (clock),
        .nrst          (nrst),
        .start         (start),
        .my_cluster_id (my_cluster_id),
        .mem_addr      (mem_addr),
        .mem_wr_en     (mem_wr_en),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .done          (done),
        .match_count   (match_count),
        .overflow      (overflow)
    );

    assign mem_rdata = mem[mem_addr[15:1]];

    always #5 clock = ~clock;

    // Write capture and port protocol monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (nrst) begin
            if (mem_wr_en) wr_q.push_back({mem_addr, mem_wdata});
            if ((!mem_wr_en && mem_wdata != 16'h0) || mem_addr[0]) prot_err++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // pat 0: basic table, 1: all other clusters, 2: all same cluster, 3: random mix
    task automatic fill(input int cnt, input int pat, input logic [15:0] myc);
        mem[15'(CNT_W)] = 16'(cnt);
        for (int k = 0; k < 64; k++) begin
            logic [15:0] id;
            logic [15:0] cl;
            id = 16'h0100 + 16'(k);
            cl = myc;
            case (pat)
                1: cl = myc + 16'd1;
                2: cl = myc;
                3: begin
                    id = 16'($urandom);
                    cl = myc + 16'($urandom_range(0, 2));
                end
                default: ;
            endcase
            mem[15'(ID_W + k)] = id;
            mem[15'(CL_W + k)] = cl;
        end
        if (pat == 0) begin
            mem[15'(ID_W + 0)] = 16'd3;  mem[15'(CL_W + 0)] = 16'd1;
            mem[15'(ID_W + 1)] = 16'd1;  mem[15'(CL_W + 1)] = 16'd1;
            mem[15'(ID_W + 2)] = 16'd10; mem[15'(CL_W + 2)] = 16'd2;
            mem[15'(ID_W + 3)] = 16'd6;  mem[15'(CL_W + 3)] = 16'd3;
        end
    endtask

    // Reference: walk the clamped table, collect other-cluster IDs into a capped list.
    task automatic model(input logic [15:0] myc, output int m, output logic ovf, output int cyc);
        int n;
        n = int'(mem[15'(CNT_W)]);
        if (n > 64) n = 64;
        m = 0;
        ovf = 1'b0;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            if (mem[15'(CL_W + k)] != myc) begin
                if (m < 16) begin
                    exp_q.push_back({16'h0668 + 16'(2 * m), mem[15'(ID_W + k)]});
                    m++;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
        exp_q.push_back({16'h068C, 16'(m)});
        cyc = 3 + 2 * n + m;
    endtask

    task automatic compare_writes(input string tag, input int base);
        check($sformatf("%s nwr", tag), 32'(wr_q.size() - base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && (base + k) < wr_q.size(); k++)
            check($sformatf("%s wr%0d", tag, k), wr_q[base + k], exp_q[k]);
    endtask

    task automatic run_scan(input logic [15:0] myc, input bit skip_wait, output int cyc, output int base);
        int pbase;
        int berr;
        if (!skip_wait) begin
            @(negedge clock);
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        base  = wr_q.size();
        pbase = prot_err;
        start = 1'b1;
        my_cluster_id = myc;
        @(posedge clock);
        #1;
        start = 1'b0;
        my_cluster_id = ~myc;   // must have been latched at acceptance
        cyc  = 0;
        berr = 0;
        while (cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (done) break;
            if (!busy) berr++;
        end
        check("busy_at_done", 32'(busy), 32'd0);
        check("busy_during", 32'(berr), 32'd0);
        check("protocol", 32'(prot_err - pbase), 32'd0);
    endtask

    initial begin
        vec_t vecs [8];
        int cyc, base, mm, mc, dn;
        logic mo;
        int done_at [$];

        vecs[0] = '{4,   0, 16'd1,    2,  1'b0, 13};
        vecs[1] = '{0,   1, 16'd7,    0,  1'b0, 3};
        vecs[2] = '{20,  1, 16'd5,    16, 1'b1, 59};
        vecs[3] = '{100, 2, 16'd9,    0,  1'b0, 131};
        vecs[4] = '{16,  1, 16'd2,    16, 1'b0, 51};
        vecs[5] = '{17,  1, 16'd2,    16, 1'b1, 53};
        vecs[6] = '{64,  1, 16'h1234, 16, 1'b1, 147};
        vecs[7] = '{1,   1, 16'hFFFF, 1,  1'b0, 6};

        nrst = 1'b0;
        start = 1'b0;
        my_cluster_id = 16'h0;
        repeat (3) @(negedge clock);
        check("rst_bus", {mem_addr, mem_wdata}, 32'd0);
        check("rst_flags", 32'({mem_wr_en, busy, done, overflow, match_count}), 32'd0);
        nrst = 1'b1;

        // Scenario table
        for (int v = 0; v < 8; v++) begin
            fill(vecs[v].cnt, vecs[v].pat, vecs[v].myc);
            model(vecs[v].myc, mm, mo, mc);
            run_scan(vecs[v].myc, 1'b0, cyc, base);
            check($sformatf("v%0d cycle", v), 32'(cyc), 32'(vecs[v].exp_cyc));
            check($sformatf("v%0d match", v), 32'(match_count), 32'(vecs[v].exp_m));
            check($sformatf("v%0d ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
            compare_writes($sformatf("v%0d", v), base);
        end

        // Basic scan with explicit write list
        fill(4, 0, 16'd1);
        run_scan(16'd1, 1'b0, cyc, base);
        check("basic nwr", 32'(wr_q.size() - base), 32'd3);
        check("basic wr0", (wr_q.size() > base)     ? wr_q[base]     : 32'hDEADBEEF, {16'h0668, 16'd10});
        check("basic wr1", (wr_q.size() > base + 1) ? wr_q[base + 1] : 32'hDEADBEEF, {16'h066A, 16'd6});
        check("basic wr2", (wr_q.size() > base + 2) ? wr_q[base + 2] : 32'hDEADBEEF, {16'h068C, 16'd2});

        // Reset during RD_CL of index 1
        @(negedge clock);
        start = 1'b1;
        my_cluster_id = 16'd1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("pre_rst addr", 32'(mem_addr), 32'h00CA);
        base = wr_q.size();
        nrst = 1'b0;
        #1;
        check("midrst bus", {mem_addr, mem_wdata}, 32'd0);
        check("midrst flags", 32'({mem_wr_en, busy, done, overflow, match_count}), 32'd0);
        repeat (3) @(negedge clock);
        check("midrst nowr", 32'(wr_q.size() - base), 32'd0);
        nrst = 1'b1;
        model(16'd1, mm, mo, mc);
        run_scan(16'd1, 1'b1, cyc, base);
        check("postrst cycle", 32'(cyc), 32'd13);
        check("postrst match", 32'(match_count), 32'd2);
        compare_writes("postrst", base);

        // start held high: one scan per IDLE acceptance, 14-cycle period
        @(negedge clock);
        @(negedge clock);
        start = 1'b1;
        my_cluster_id = 16'd1;
        @(posedge clock);
        dn = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (done) begin
                dn++;
                done_at.push_back(c);
            end
        end
        start = 1'b0;
        check("hold ndone", 32'(dn), 32'd2);
        check("hold done2", (done_at.size() > 1) ? 32'(done_at[1]) : 32'hFFFF, 32'd27);
        repeat (20) @(negedge clock);
        check("hold idle", 32'(busy), 32'd0);

        // Randomized tables against the model
        for (int r = 0; r < 12; r++) begin
            logic [15:0] myc;
            myc = 16'($urandom);
            fill(int'($urandom_range(0, 70)), 3, myc);
            model(myc, mm, mo, mc);
            run_scan(myc, 1'b0, cyc, base);
            check($sformatf("r%0d cycle", r), 32'(cyc), 32'(mc));
            check($sformatf("r%0d match", r), 32'(match_count), 32'(mm));
            check($sformatf("r%0d ovf", r), 32'(overflow), 32'(mo));
            compare_writes($sformatf("r%0d", r), base);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neighbor_scan.md
NEIGHBOR_SCAN -- requirements
Module: neighbor_scan

Interface
REQ-001 Parameter NBR_COUNT_ADDR, 16'h068A, byte address of the neighborCount word.
REQ-002 Parameter NBR_ID_BASE, 16'h0048, byte address of neighborID[0].
REQ-003 Parameter CLUSTER_BASE, 16'h00C8, byte address of clusterID[0].
REQ-004 Parameter OUT_BASE, 16'h0668, byte address of betterneighbors[0].
REQ-005 Parameter OUT_COUNT_ADDR, 16'h068C, byte address of the betterneighborCount word.
REQ-006 Parameter MAX_NBR, 64, neighbor table capacity; MAX_OUT, 16, output list capacity.
REQ-007 clock  input  1  single clock; all state updates on the rising edge.
REQ-008 nrst  input  1  reset, asynchronous assert, active-low.
REQ-009 start  input  1  one-cycle scan request.
REQ-010 my_cluster_id  input  16  own cluster ID; sampled when start is accepted.
REQ-011 mem_addr  output  16  byte address to the word memory; even addresses only.
REQ-012 mem_wr_en  output  1  memory write strobe.
REQ-013 mem_wdata  output  16  write word, big-endian: high byte at mem_addr, low byte at mem_addr+1.
REQ-014 mem_rdata  input  16  combinational read word for the current mem_addr.
REQ-015 busy  output  1  high from the first cycle after start acceptance through the WR_CNT state.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 match_count  output  5  number of entries written to the output list (0..16).
REQ-018 overflow  output  1  at least one other-cluster neighbor was dropped because the output list was full.

Function
REQ-019 States: IDLE, RD_CNT, RD_ID, RD_CL, WR_OUT, WR_CNT, DONE; encoding is free.
REQ-020 IDLE: mem_addr=0, mem_wr_en=0; start=1 latches my_cluster_id, clears match_count and overflow, and moves to RD_CNT.
REQ-021 start is ignored in every state other than IDLE.
REQ-022 RD_CNT: mem_addr=NBR_COUNT_ADDR; latch n=min(mem_rdata, MAX_NBR) and index i=0; n=0 goes to WR_CNT, otherwise to RD_ID.
REQ-023 RD_ID: mem_addr=NBR_ID_BASE+2*i; latch the ID from mem_rdata; go to RD_CL.
REQ-024 RD_CL: mem_addr=CLUSTER_BASE+2*i; a mismatch with the latched cluster ID and match_count<MAX_OUT goes to WR_OUT.
REQ-025 RD_CL with a mismatch and match_count=MAX_OUT sets overflow and advances the index; a match advances the index.
REQ-026 WR_OUT: mem_addr=OUT_BASE+2*match_count, mem_wdata=latched ID, mem_wr_en=1 for exactly this cycle; match_count increments; advance the index.
REQ-027 Advance index: i increments; i=n goes to WR_CNT, otherwise to RD_ID.
REQ-028 WR_CNT: mem_addr=OUT_COUNT_ADDR, mem_wdata={11'b0, match_count}, mem_wr_en=1 for one cycle; go to DONE.
REQ-029 DONE: done=1 for exactly one cycle, busy=0; go to IDLE; match_count and overflow hold until the next accepted start.
REQ-030 Latency: done is high in cycle 3+2n+m after the accepting edge, where m is the number of WR_OUT cycles.
REQ-031 Address arithmetic is 16-bit, modulo 2^16; the index is 7 bits wide to hold MAX_NBR.
REQ-032 mem_wr_en is 0 in every state except WR_OUT and WR_CNT; mem_wdata=0 whenever mem_wr_en=0.

Reset
REQ-033 nrst low forces IDLE immediately, regardless of clock.
REQ-034 During reset: mem_addr=0, mem_wr_en=0, mem_wdata=0, busy=0, done=0, match_count=0, overflow=0.
REQ-035 Reset mid-scan aborts without further writes; the block accepts a new start on the first rising edge with nrst high.

Verification
REQ-036 Basic scan, with the following setup:
- neighborCount=4.
- IDs 3,1,10,6; clusters 1,1,2,3; my_cluster_id=1.
- Required response: writes 10@0x668 and 6@0x66A, then 2@0x68C; done in cycle 13; match_count=2; overflow=0.
REQ-037 neighborCount=0 -> single write of 0@0x68C; done in cycle 3; no list writes.
REQ-038 neighborCount=20, all in other clusters -> 16 list writes at 0x668..0x686; count write 16; overflow=1; done in cycle 59.
REQ-039 neighborCount=100 with all neighbors in the same cluster -> clamped to 64 reads (last at 0xC6/0x146); count write 0; done in cycle 131.
REQ-040 Reset and busy handling:
- nrst pulsed low during the RD_CL of index 1 -> outputs at reset values at once; no write occurs.
- A subsequent start -> full correct scan.
- start held high while busy -> exactly one scan per IDLE acceptance.
